control_puerta: RTL and testbench

Door controller for the elevator car. It consumes the tick output `C_1Hz` of `Temporizador_Divisor` and drives that timer's `startTimer`/`restart` inputs. It sequences the door motor through open, hold, close and reversal, and reports to the car controller when the door is safely closed. A sticky fault is flagged if a motion does not complete in time or the limit switches are inconsistent.

---
 rtl/control_puerta_if.sv | 25 ++
 rtl/control_puerta.sv | 109 ++++++++++
 tb/tb_control_puerta.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/control_puerta_if.sv
// Signal bundle between the door controller, the car controller, the door sensors and
// Temporizador_Divisor. The controller uses the slave modport; the environment uses master.
interface control_puerta_if;
    logic C_1Hz;
    logic abrir_req;
    logic sensor_obst;
    logic fin_abierta;
    logic fin_cerrada;
    logic startTimer;
    logic restart;
    logic motor_abrir;
    logic motor_cerrar;
    logic puerta_cerrada;
    logic falla;

    modport master (
        output C_1Hz, abrir_req, sensor_obst, fin_abierta, fin_cerrada,
        input  startTimer, restart, motor_abrir, motor_cerrar, puerta_cerrada, falla
    );

    modport slave (
        input  C_1Hz, abrir_req, sensor_obst, fin_abierta, fin_cerrada,
        output startTimer, restart, motor_abrir, motor_cerrar, puerta_cerrada, falla
    );
endinterface

// File: rtl/control_puerta.sv
// Elevator door controller: open / hold / close / reverse sequencing driven by timer ticks,
// with a sticky fault on motion timeout or contradictory limit switches. Parameters: 1..255.
module control_puerta #(
    parameter int unsigned TICKS_ABIERTA = 5,
    parameter int unsigned TICKS_MOV     = 3
) (
    input logic             C_100Mhz,
    input logic             Reset_n,
    control_puerta_if.slave bus
);

    typedef enum logic [2:0] {
        StCerrada,
        StAbriendo,
        StAbierta,
        StCerrando,
        StFalla
    } state_t;

    localparam logic [7:0] TicksAbierta = 8'(TICKS_ABIERTA);
    localparam logic [7:0] TicksMov     = 8'(TICKS_MOV);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       c1_d;
    logic       tick;
    logic       hold;
    logic       entering;

    logic start_q, restart_q, abrir_q, cerrar_q, cerrada_q, falla_q;

    // Ticks landing on a restart cycle belong to the timer period being cleared.
    assign tick = bus.C_1Hz & ~c1_d & ~restart_q;

    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        if (bus.fin_abierta && bus.fin_cerrada && state_q != StFalla) begin
            state_d = StFalla;
        end else begin
            unique case (state_q)
                StCerrada: begin
                    if (bus.abrir_req) state_d = StAbriendo;
                end
                StAbriendo: begin
                    if (bus.fin_abierta)         state_d = StAbierta;
                    else if (count_q == TicksMov) state_d = StFalla;
                end
                StAbierta: begin
                    if (bus.sensor_obst || bus.abrir_req) hold = 1'b1;
                    else if (count_q == TicksAbierta)     state_d = StCerrando;
                end
                StCerrando: begin
                    if (bus.sensor_obst || bus.abrir_req) state_d = StAbriendo;
                    else if (bus.fin_cerrada)             state_d = StCerrada;
                    else if (count_q == TicksMov)         state_d = StFalla;
                end
                StFalla: ;
                default: state_d = StCerrada;
            endcase
        end
    end

    assign entering = (state_d != state_q) &&
                      (state_d == StAbriendo || state_d == StAbierta || state_d == StCerrando);

    always_comb begin
        count_d = count_q;
        if (state_d != state_q || hold) begin
            count_d = 8'd0;
        end else if (tick && count_q != 8'hff) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge C_100Mhz or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StCerrada;
            count_q   <= 8'd0;
            c1_d      <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            abrir_q   <= 1'b0;
            cerrar_q  <= 1'b0;
            cerrada_q <= 1'b1;
            falla_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            c1_d      <= bus.C_1Hz;
            start_q   <= (state_d == StAbriendo) || (state_d == StAbierta) ||
                         (state_d == StCerrando);
            // A held obstruction re-pulses restart every other cycle.
            restart_q <= entering || (hold && !restart_q);
            abrir_q   <= (state_d == StAbriendo);
            cerrar_q  <= (state_d == StCerrando);
            cerrada_q <= (state_d == StCerrada);
            falla_q   <= (state_d == StFalla);
        end
    end

    assign bus.startTimer     = start_q;
    assign bus.restart        = restart_q;
    assign bus.motor_abrir    = abrir_q;
    assign bus.motor_cerrar   = cerrar_q;
    assign bus.puerta_cerrada = cerrada_q;
    assign bus.falla          = falla_q;

endmodule

// File: tb/tb_control_puerta.sv
// Self-checking bench for control_puerta: a per-cycle vector table for the normal door cycle
// plus directed sequences for hold, reversal, timeout, sensor conflict and async reset.
module tb_control_puerta;

    logic C_100Mhz;
    logic Reset_n;
    int   n_checks;
    int   n_fail;

    control_puerta_if bus ();

    control_puerta #(
        .TICKS_ABIERTA(5),
        .TICKS_MOV    (3)
    ) dut (
        .C_100Mhz(C_100Mhz),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial C_100Mhz = 1'b0;
    always #5 C_100Mhz = ~C_100Mhz;

    // Output vector: {startTimer, restart, motor_abrir, motor_cerrar, puerta_cerrada, falla}
    typedef struct {
        logic       req;
        logic       obst;
        logic       fa;
        logic       fc;
        logic       c1;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] outs();
        return {bus.startTimer, bus.restart, bus.motor_abrir, bus.motor_cerrar,
                bus.puerta_cerrada, bus.falla};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic req, input logic obst, input logic fa, input logic fc,
                       input logic c1, input logic [5:0] exp);
        vec_t v;
        v.req = req; v.obst = obst; v.fa = fa; v.fc = fc; v.c1 = c1; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic req, input logic obst, input logic fa, input logic fc,
                         input logic c1);
        bus.abrir_req   = req;
        bus.sensor_obst = obst;
        bus.fin_abierta = fa;
        bus.fin_cerrada = fc;
        bus.C_1Hz       = c1;
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, 0);
        @(negedge C_100Mhz);
        Reset_n = 1'b0;
        @(negedge C_100Mhz);
        check("reset_outputs", outs(), 6'b000010);
        Reset_n = 1'b1;
        @(negedge C_100Mhz);
    endtask

    // One timer tick: high for one cycle, low for one; returns two edges later.
    task automatic tick();
        bus.C_1Hz = 1'b1;
        @(negedge C_100Mhz);
        bus.C_1Hz = 1'b0;
        @(negedge C_100Mhz);
    endtask

    task automatic go_abierta();
        reset_dut();
        bus.abrir_req = 1'b1;
        @(negedge C_100Mhz);
        bus.abrir_req = 1'b0;
        @(negedge C_100Mhz);
        bus.fin_abierta = 1'b1;
        @(negedge C_100Mhz);
        @(negedge C_100Mhz);
    endtask

    task automatic go_cerrando();
        go_abierta();
        for (int i = 0; i < 5; i++) tick();
        bus.fin_abierta = 1'b0;
        @(negedge C_100Mhz);
        check("cerrando_reached", outs(), 6'b100100);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset_n  = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Normal cycle, one table row per clock.
        add(1, 0, 0, 0, 0, 6'b111000);
        add(0, 0, 0, 0, 0, 6'b101000);
        add(0, 0, 0, 0, 1, 6'b101000);
        add(0, 0, 0, 0, 0, 6'b101000);
        add(0, 0, 1, 0, 0, 6'b110000);
        add(0, 0, 1, 0, 0, 6'b100000);
        for (int i = 0; i < 4; i++) begin
            add(0, 0, 1, 0, 1, 6'b100000);
            add(0, 0, 1, 0, 0, 6'b100000);
        end
        add(0, 0, 1, 0, 1, 6'b100000);
        add(0, 0, 1, 0, 0, 6'b110100);
        add(0, 0, 0, 0, 0, 6'b100100);
        add(0, 0, 0, 1, 0, 6'b000010);
        add(0, 0, 0, 1, 0, 6'b000010);
        add(0, 0, 0, 0, 0, 6'b000010);

        reset_dut();
        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].obst, vecs[i].fa, vecs[i].fc, vecs[i].c1);
            @(negedge C_100Mhz);
            check($sformatf("normal_vec%0d", i), outs(), vecs[i].exp);
        end

        // Obstruction pulse after 4 ticks restarts the 5-tick hold.
        go_abierta();
        for (int i = 0; i < 4; i++) tick();
        bus.sensor_obst = 1'b1;
        @(negedge C_100Mhz);
        check("obst_restart", outs(), 6'b110000);
        bus.sensor_obst = 1'b0;
        @(negedge C_100Mhz);
        check("obst_restart_done", outs(), 6'b100000);
        for (int i = 0; i < 4; i++) tick();
        check("obst_still_open", outs(), 6'b100000);
        tick();
        check("obst_close_after5", outs(), 6'b110100);

        // Continuous obstruction keeps the door open, restart toggling.
        go_abierta();
        bus.sensor_obst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge C_100Mhz);
            check($sformatf("obst_hold_c%0d", i), outs(), (i % 2 == 0) ? 6'b110000 : 6'b100000);
        end
        for (int i = 0; i < 6; i++) tick();
        check("obst_hold_open", outs() & 6'b101110, 6'b100000);
        bus.sensor_obst = 1'b0;

        // Reversal: obstruction wins over fin_cerrada.
        go_cerrando();
        bus.sensor_obst = 1'b1;
        bus.fin_cerrada = 1'b1;
        @(negedge C_100Mhz);
        check("reversal", outs(), 6'b111000);
        drive(0, 0, 0, 0, 0);

        // Opening timeout.
        reset_dut();
        bus.abrir_req = 1'b1;
        @(negedge C_100Mhz);
        bus.abrir_req = 1'b0;
        @(negedge C_100Mhz);
        tick();
        tick();
        check("timeout_not_yet", outs(), 6'b101000);
        tick();
        check("timeout_falla", outs(), 6'b000001);
        bus.abrir_req = 1'b1;
        repeat (10) @(negedge C_100Mhz);
        check("falla_sticky", outs(), 6'b000001);
        reset_dut();
        check("falla_cleared", outs(), 6'b000010);

        // Limit-switch conflict while open.
        go_abierta();
        bus.fin_cerrada = 1'b1;
        @(negedge C_100Mhz);
        check("sensor_conflict", outs(), 6'b000001);
        drive(0, 0, 0, 0, 0);

        // Async reset between clock edges while closing.
        go_cerrando();
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_reset", outs(), 6'b000010);
        @(negedge C_100Mhz);
        Reset_n = 1'b1;
        @(negedge C_100Mhz);
        check("after_async_reset", outs(), 6'b000010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
